// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: walks IDLE -> FETCH -> HOLD, keeps one instruction in
// flight, and computes the next pc from jr/jump/branch redirects at handoff.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [15:0] imm_num,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_addr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        started;
    logic [31:0] target;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Branch offset is a signed word count; the shift and add wrap modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic signed [31:0] offset);
        logic signed [31:0] byte_off;
        byte_off = offset <<< 2;
        return base + byte_off;
    endfunction

    function automatic logic [31:0] redirect_target(
        input logic        sel_jr,
        input logic        sel_jump,
        input logic        sel_br,
        input logic [31:0] reg_tgt,
        input logic [25:0] index,
        input logic [31:0] offset,
        input logic [31:0] seq
    );
        if (sel_jr)
            return word_align(reg_tgt);
        else if (sel_jump)
            return {seq[31:28], index, 2'b00};
        else if (sel_br)
            return branch_target(seq, offset);
        else
            return seq;
    endfunction

    always_comb begin
        target = redirect_target(jr, jump, br_taken, jr_addr, jump_index,
                                 br_offset, pc_plus4);
    end

    // 'started' keeps IDLE for one full cycle after the first released edge,
    // so the first request appears two edges after rst_n goes high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            started  <= 1'b0;
            pc       <= RESET_PC;
            instr    <= 32'h0;
            pc_plus4 <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    started <= 1'b1;
                    if (started)
                        state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        pc_plus4 <= word_align(pc) + 32'd4;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc    <= target;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign imem_addr   = word_align(pc);
    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == HOLD);
    assign opcode      = instr[31:26];
    assign imm_num     = instr[15:0];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed sequences, a redirect vector
// table and a randomized run against a transaction-level model.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [15:0] imm_num;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_addr;

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode), .imm_num(imm_num),
        .pc_plus4(pc_plus4), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .br_taken(br_taken), .br_offset(br_offset), .jump(jump),
        .jump_index(jump_index), .jr(jr), .jr_addr(jr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] setup_pc;
        logic        br;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] idx;
        logic        rj;
        logic [31:0] raddr;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack = 0; imem_rdata = 0; instr_ready = 0;
        br_taken = 0; br_offset = 0; jump = 0; jump_index = 0; jr = 0; jr_addr = 0;
    endtask

    // Leaves the DUT in FETCH at the reset pc.
    task automatic apply_reset();
        clear_inputs();
        rst_n = 0;
        step(); step();
        rst_n = 1;
        step(); step();
    endtask

    // Randomized-run reference: fetch address, held-instruction flag and payload.
    logic [31:0] m_pc, m_instr, m_pp4;
    bit          m_have;

    initial begin
        clear_inputs();
        rst_n = 0;

        // Reset values and first-request timing
        step(); step();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pp4", pc_plus4, 32'h0);
        rst_n = 1;
        step();
        chk("idle_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0000_3000);

        // Zero-wait memory, decode always ready
        instr_ready = 1;
        for (int k = 0; k < 3; k++) begin
            imem_ack = 1; imem_rdata = 32'h1000_0000 + k;
            step();
            imem_ack = 0;
            chk("zw_valid", {31'b0, instr_valid}, 32'd1);
            chk("zw_req_hold", {31'b0, imem_req}, 32'd0);
            chk("zw_instr", instr, 32'h1000_0000 + k);
            chk("zw_pp4", pc_plus4, 32'h3004 + 4 * k);
            step();
            chk("zw_valid_drop", {31'b0, instr_valid}, 32'd0);
            chk("zw_addr", imem_addr, 32'h3004 + 4 * k);
        end

        // Slow memory, stalled decode, ack and redirects ignored in HOLD
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wait_req", {31'b0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h3000);
        end
        imem_ack = 1; imem_rdata = 32'h8C41_0010;
        step();
        imem_ack = 0;
        for (int k = 0; k < 4; k++) begin
            imem_ack = k[0]; imem_rdata = 32'hDEAD_BEEF;
            jr = 1; jr_addr = 32'h5000; jump = 1; jump_index = 26'h3; br_taken = 1; br_offset = 32'h40;
            step();
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_instr", instr, 32'h8C41_0010);
            chk("stall_opcode", {26'b0, opcode}, 32'h23);
            chk("stall_imm", {16'b0, imm_num}, 32'h0010);
            chk("stall_pp4", pc_plus4, 32'h3004);
        end
        clear_inputs();
        instr_ready = 1;
        step();
        chk("seq_after_stall", imem_addr, 32'h3004);
        chk("seq_after_stall_req", {31'b0, imem_req}, 32'd1);

        // Reset during FETCH, ack arriving after release is ignored
        apply_reset();
        rst_n = 0;
        step();
        rst_n = 1; imem_ack = 1; imem_rdata = 32'hFEED_F00D;
        step();
        imem_ack = 0;
        chk("late_ack_valid", {31'b0, instr_valid}, 32'd0);
        chk("late_ack_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("refetch_addr", imem_addr, 32'h3000);
        chk("refetch_req", {31'b0, imem_req}, 32'd1);
        chk("refetch_instr", instr, 32'h0);

        // Reset during HOLD discards instruction, pending redirect not applied
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        step();
        clear_inputs();
        rst_n = 0; jr = 1; jr_addr = 32'h7000; instr_ready = 1;
        step();
        chk("hold_rst_instr", instr, 32'h0);
        chk("hold_rst_valid", {31'b0, instr_valid}, 32'd0);
        clear_inputs();
        rst_n = 1;
        step(); step();
        chk("hold_rst_refetch", imem_addr, 32'h3000);

        // Redirect vector table
        vecs[0] = '{32'h0000_300C, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_3000};
        vecs[1] = '{32'h0000_300C, 1'b1, 32'h0000_0003, 1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_301C};
        vecs[2] = '{32'h0000_300C, 1'b1, 32'h0000_0003, 1'b1, 26'h0000100, 1'b1, 32'h0040_0007, 32'h0040_0004};
        vecs[3] = '{32'h0000_300C, 1'b1, 32'h0000_0003, 1'b1, 26'h0000100, 1'b0, 32'h0040_0007, 32'h0000_0400};
        vecs[4] = '{32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 32'h0,         32'h0000_0000};
        vecs[5] = '{32'hA000_0000, 1'b1, 32'h0000_0010, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0,        32'hAFFF_FFFC};
        vecs[6] = '{32'h0000_1000, 1'b1, 32'h2000_0000, 1'b0, 26'h0,       1'b0, 32'h0,         32'h8000_1004};
        vecs[7] = '{32'h0000_2000, 1'b1, 32'h0000_0001, 1'b1, 26'h1,       1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
        for (int v = 0; v < 8; v++) begin
            apply_reset();
            imem_ack = 1; imem_rdata = 32'h0;
            step();
            imem_ack = 0; instr_ready = 1; jr = 1; jr_addr = vecs[v].setup_pc;
            step();
            clear_inputs();
            chk("vec_setup_addr", imem_addr, vecs[v].setup_pc);
            imem_ack = 1; imem_rdata = 32'h0800_0000 + v;
            step();
            imem_ack = 0;
            chk("vec_pp4", pc_plus4, vecs[v].setup_pc + 32'd4);
            instr_ready = 1;
            br_taken = vecs[v].br; br_offset = vecs[v].off;
            jump = vecs[v].jmp; jump_index = vecs[v].idx;
            jr = vecs[v].rj; jr_addr = vecs[v].raddr;
            step();
            chk("vec_next_addr", imem_addr, vecs[v].exp_addr);
            clear_inputs();
        end

        // Randomized run against transaction-level model
        apply_reset();
        m_pc = 32'h3000; m_have = 0; m_instr = 0; m_pp4 = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] ji32;
            imem_ack    = ($urandom_range(0, 2) == 0);
            imem_rdata  = $urandom;
            instr_ready = ($urandom_range(0, 2) != 0);
            jr          = ($urandom_range(0, 5) == 0);
            jump        = ($urandom_range(0, 4) == 0);
            br_taken    = ($urandom_range(0, 2) == 0);
            jr_addr     = $urandom;
            jump_index  = 26'($urandom);
            br_offset   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom;
            ji32 = {6'b0, jump_index};
            if (!m_have) begin
                if (imem_ack) begin
                    m_have = 1; m_instr = imem_rdata; m_pp4 = m_pc + 32'd4;
                end
            end else if (instr_ready) begin
                m_have = 0;
                if (jr)            m_pc = jr_addr - (jr_addr % 4);
                else if (jump)     m_pc = (m_pp4 & 32'hF000_0000) + ji32 * 4;
                else if (br_taken) m_pc = m_pp4 + br_offset * 4;
                else               m_pc = m_pp4;
            end
            step();
            chk("rnd_valid", {31'b0, instr_valid}, {31'b0, m_have});
            chk("rnd_req", {31'b0, imem_req}, {31'b0, !m_have});
            if (m_have) begin
                chk("rnd_instr", instr, m_instr);
                chk("rnd_pp4", pc_plus4, m_pp4);
                chk("rnd_opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
                chk("rnd_imm", {16'b0, imm_num}, {16'b0, m_instr[15:0]});
            end else begin
                chk("rnd_addr", imem_addr, m_pc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
